// File: rtl/lpddr5_bank_timing_model.sv
// Multi-bank LPDDR5 timing/protocol model: per-bank open row and timing counters,
// global refresh counter, byte-masked storage and a fixed-latency read pipeline.
module lpddr5_bank_timing_model #(
    parameter int BANKS  = 4,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 6,
    parameter int DATA_W = 32,
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_RAS  = 10,
    parameter int T_WR   = 6,
    parameter int T_RFC  = 20,
    parameter int CL     = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd,
    input  logic [$clog2(BANKS)-1:0] cmd_bank,
    input  logic [ROW_W-1:0]         cmd_row,
    input  logic [COL_W-1:0]         cmd_col,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_mask,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     cmd_err,
    output logic [2:0]               err_code,
    output logic [BANKS-1:0]         bank_open,
    output logic                     busy
);
    localparam int BANK_W = $clog2(BANKS);
    localparam int ADDR_W = BANK_W + ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_RCD, T_RP), max2(T_RAS, T_WR)), max2(T_RFC, 1));
    localparam int CNT_W = $clog2(T_MAX + 1);

    // A counter reads T-1 in the cycle after its command so that it reads 0 at accept + T.
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'((T_RP  > 0) ? T_RP  - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RAS = CNT_W'((T_RAS > 0) ? T_RAS - 1 : 0);
    localparam logic [CNT_W-1:0] LD_WR  = CNT_W'((T_WR  > 0) ? T_WR  - 1 : 0);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'((T_RFC > 0) ? T_RFC - 1 : 0);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;

    bank_state_e      state_q    [BANKS];
    logic [ROW_W-1:0] open_row_q [BANKS];
    logic [CNT_W-1:0] rcd_q      [BANKS];
    logic [CNT_W-1:0] ras_q      [BANKS];
    logic [CNT_W-1:0] rp_q       [BANKS];
    logic [CNT_W-1:0] wr_q       [BANKS];
    logic [CNT_W-1:0] rfc_q;
    logic             cmd_err_q;
    logic [2:0]       err_code_q;
    logic [CL-1:0]    valid_q;

    logic             act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
    logic             reject_d;
    logic [2:0]       code_d;
    logic             any_active, any_rp, sel_active;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd;

    function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
        return (v != '0) ? v - 1'b1 : '0;
    endfunction

    assign mem_addr = {cmd_bank, open_row_q[cmd_bank], cmd_col};

    always_comb begin
        any_active = 1'b0;
        any_rp     = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            any_active |= (state_q[b] == BANK_ACTIVE);
            any_rp     |= (rp_q[b] != '0);
        end
        sel_active = (state_q[cmd_bank] == BANK_ACTIVE);
        act_fire   = 1'b0;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        pre_fire   = 1'b0;
        ref_fire   = 1'b0;
        reject_d   = 1'b0;
        code_d     = 3'd0;
        if (rst_n && cmd_valid) begin
            case (cmd)
                CMD_NOP: ;
                CMD_ACT: begin
                    if (sel_active) begin
                        reject_d = 1'b1;
                        code_d   = 3'd1;
                    end else if (rp_q[cmd_bank] != '0 || rfc_q != '0) begin
                        reject_d = 1'b1;
                        code_d   = 3'd2;
                    end else begin
                        act_fire = 1'b1;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!sel_active) begin
                        reject_d = 1'b1;
                        code_d   = 3'd3;
                    end else if (rcd_q[cmd_bank] != '0) begin
                        reject_d = 1'b1;
                        code_d   = 3'd4;
                    end else begin
                        rd_fire = (cmd == CMD_RD);
                        wr_fire = (cmd == CMD_WR);
                    end
                end
                CMD_PRE: begin
                    // Precharging an idle bank is a harmless no-op.
                    if (sel_active) begin
                        if (ras_q[cmd_bank] != '0 || wr_q[cmd_bank] != '0) begin
                            reject_d = 1'b1;
                            code_d   = 3'd5;
                        end else begin
                            pre_fire = 1'b1;
                        end
                    end
                end
                CMD_REF: begin
                    if (any_active || any_rp || rfc_q != '0) begin
                        reject_d = 1'b1;
                        code_d   = 3'd6;
                    end else begin
                        ref_fire = 1'b1;
                    end
                end
                default: begin
                    reject_d = 1'b1;
                    code_d   = 3'd7;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < BANKS; b++) begin
                state_q[b]    <= BANK_IDLE;
                open_row_q[b] <= '0;
                rcd_q[b]      <= '0;
                ras_q[b]      <= '0;
                rp_q[b]       <= '0;
                wr_q[b]       <= '0;
            end
            rfc_q      <= '0;
            cmd_err_q  <= 1'b0;
            err_code_q <= 3'd0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                rcd_q[b] <= dec(rcd_q[b]);
                ras_q[b] <= dec(ras_q[b]);
                rp_q[b]  <= dec(rp_q[b]);
                wr_q[b]  <= dec(wr_q[b]);
                if (BANK_W'(b) == cmd_bank) begin
                    if (act_fire) begin
                        state_q[b]    <= BANK_ACTIVE;
                        open_row_q[b] <= cmd_row;
                        rcd_q[b]      <= LD_RCD;
                        ras_q[b]      <= LD_RAS;
                    end
                    if (wr_fire) begin
                        wr_q[b] <= LD_WR;
                    end
                    if (pre_fire) begin
                        state_q[b] <= BANK_IDLE;
                        rp_q[b]    <= LD_RP;
                    end
                end
            end
            rfc_q     <= ref_fire ? LD_RFC : dec(rfc_q);
            cmd_err_q <= reject_d;
            if (reject_d) begin
                err_code_q <= code_d;
            end
        end
    end

    // One storage array per byte lane keeps masked writes a plain per-lane write enable.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            logic [7:0] lane_mem_q [DEPTH];
            logic [7:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (wr_fire && wr_mask[gi]) begin
                    lane_mem_q[mem_addr] <= wr_data[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    lane_rd_q <= 8'd0;
                end else if (rd_fire) begin
                    lane_rd_q <= lane_mem_q[mem_addr];
                end
            end

            assign mem_rd[gi*8 +: 8] = lane_rd_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= rd_fire;
            for (int k = 1; k < CL; k++) begin
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    // Each data stage only loads behind a valid, so rd_data holds between reads.
    generate
        if (CL == 1) begin : g_cl1
            assign rd_data = mem_rd;
        end else begin : g_pipe
            logic [DATA_W-1:0] pipe_q [CL-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int j = 0; j < CL-1; j++) begin
                        pipe_q[j] <= '0;
                    end
                end else begin
                    if (valid_q[0]) begin
                        pipe_q[0] <= mem_rd;
                    end
                    for (int j = 1; j < CL-1; j++) begin
                        if (valid_q[j]) begin
                            pipe_q[j] <= pipe_q[j-1];
                        end
                    end
                end
            end

            assign rd_data = pipe_q[CL-2];
        end
    endgenerate

    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_open
            assign bank_open[gi] = (state_q[gi] == BANK_ACTIVE);
        end
    endgenerate

    always_comb begin
        busy = (rfc_q != '0);
        for (int b = 0; b < BANKS; b++) begin
            busy |= (rcd_q[b] != '0) || (ras_q[b] != '0) || (rp_q[b] != '0) || (wr_q[b] != '0);
        end
    end

    assign rd_valid = valid_q[CL-1];
    assign cmd_err  = cmd_err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_lpddr5_bank_timing_model.sv
// Bench for lpddr5_bank_timing_model: directed scenarios plus random traffic, scored
// against a timestamp-based reference model (earliest-legal-cycle per bank).
module tb_lpddr5_bank_timing_model;
    localparam int BANKS  = 4;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 6;
    localparam int DATA_W = 32;
    localparam int T_RCD  = 4;
    localparam int T_RP   = 4;
    localparam int T_RAS  = 10;
    localparam int T_WR   = 6;
    localparam int T_RFC  = 20;
    localparam int CL     = 6;
    localparam int BW     = $clog2(BANKS);
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic [2:0]        cmd = 3'd0;
    logic [BW-1:0]     cmd_bank = '0;
    logic [ROW_W-1:0]  cmd_row = '0;
    logic [COL_W-1:0]  cmd_col = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [NB-1:0]     wr_mask = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              cmd_err;
    logic [2:0]        err_code;
    logic [BANKS-1:0]  bank_open;
    logic              busy;

    lpddr5_bank_timing_model #(
        .BANKS(BANKS), .ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W),
        .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_WR(T_WR), .T_RFC(T_RFC), .CL(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_data(rd_data), .rd_valid(rd_valid), .cmd_err(cmd_err), .err_code(err_code),
        .bank_open(bank_open), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: each timing rule is an earliest-legal cycle number.
    typedef struct {
        int                due;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] k;
    } rd_t;

    int                cyc = 0;
    bit                chk_en = 1'b0;
    bit                m_open [BANKS];
    int                m_row  [BANKS];
    int                rcd_rdy[BANKS];
    int                ras_rdy[BANKS];
    int                wr_rdy [BANKS];
    int                rp_rdy [BANKS];
    int                rfc_rdy = 0;
    bit                exp_err = 1'b0;
    int                exp_code = 0;
    logic [DATA_W-1:0] last_rd = '0;
    logic [DATA_W-1:0] last_known = '1;
    logic [DATA_W-1:0] mem_d [int];
    logic [DATA_W-1:0] mem_k [int];
    rd_t               rq[$];

    function automatic bit m_busy();
        if (cyc < rfc_rdy) return 1'b1;
        for (int b = 0; b < BANKS; b++) begin
            if (cyc < rcd_rdy[b] || cyc < ras_rdy[b] || cyc < wr_rdy[b] || cyc < rp_rdy[b]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [BANKS-1:0] m_open_vec();
        logic [BANKS-1:0] v = '0;
        for (int b = 0; b < BANKS; b++) v[b] = m_open[b];
        return v;
    endfunction

    task automatic model_check();
        logic exp_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_valid  = 1'b1;
            last_rd    = rq[0].d;
            last_known = rq[0].k;
            void'(rq.pop_front());
        end
        check("rd_valid", rd_valid, exp_valid);
        check("rd_data", rd_data & last_known, last_rd & last_known);
        check("cmd_err", cmd_err, exp_err);
        check("err_code", err_code, exp_code);
        check("bank_open", bank_open, m_open_vec());
        check("busy", busy, m_busy());
    endtask

    task automatic model_reset();
        for (int b = 0; b < BANKS; b++) begin
            m_open[b]  = 1'b0;
            rcd_rdy[b] = 0;
            ras_rdy[b] = 0;
            wr_rdy[b]  = 0;
            rp_rdy[b]  = 0;
        end
        rfc_rdy    = 0;
        exp_err    = 1'b0;
        exp_code   = 0;
        last_rd    = '0;
        last_known = '1;
        rq.delete();
    endtask

    task automatic model_apply(input int c, input int b, input int row, input int col,
                               input logic [DATA_W-1:0] d, input logic [NB-1:0] m);
        int  code = 0;
        int  addr;
        bit  any_open = 1'b0;
        bit  any_rp = 1'b0;
        rd_t e;
        for (int i = 0; i < BANKS; i++) begin
            any_open |= m_open[i];
            any_rp   |= (cyc < rp_rdy[i]);
        end
        addr = (b << (ROW_W + COL_W)) | (m_row[b] << COL_W) | col;
        case (c)
            1: begin
                if (m_open[b]) code = 1;
                else if (cyc < rp_rdy[b] || cyc < rfc_rdy) code = 2;
                else begin
                    m_open[b]  = 1'b1;
                    m_row[b]   = row;
                    rcd_rdy[b] = cyc + T_RCD;
                    ras_rdy[b] = cyc + T_RAS;
                end
            end
            2, 3: begin
                if (!m_open[b]) code = 3;
                else if (cyc < rcd_rdy[b]) code = 4;
                else if (c == 2) begin
                    e.due = cyc + CL;
                    e.d   = mem_d.exists(addr) ? mem_d[addr] : '0;
                    e.k   = mem_k.exists(addr) ? mem_k[addr] : '0;
                    rq.push_back(e);
                end else begin
                    logic [DATA_W-1:0] nd = mem_d.exists(addr) ? mem_d[addr] : '0;
                    logic [DATA_W-1:0] nk = mem_k.exists(addr) ? mem_k[addr] : '0;
                    for (int i = 0; i < NB; i++) begin
                        if (m[i]) begin
                            nd[i*8 +: 8] = d[i*8 +: 8];
                            nk[i*8 +: 8] = 8'hFF;
                        end
                    end
                    mem_d[addr] = nd;
                    mem_k[addr] = nk;
                    wr_rdy[b] = cyc + T_WR;
                end
            end
            4: begin
                if (m_open[b]) begin
                    if (cyc < ras_rdy[b] || cyc < wr_rdy[b]) code = 5;
                    else begin
                        m_open[b] = 1'b0;
                        rp_rdy[b] = cyc + T_RP;
                    end
                end
            end
            5: begin
                if (any_open || any_rp || cyc < rfc_rdy) code = 6;
                else rfc_rdy = cyc + T_RFC;
            end
            6, 7: code = 7;
            default: ;
        endcase
        exp_err = (code != 0);
        if (code != 0) exp_code = code;
    endtask

    // One cycle: check outputs of this cycle, drive this cycle's command, step past the edge.
    task automatic step(input bit rst, input bit v, input int c, input int b, input int row,
                        input int col, input logic [DATA_W-1:0] d, input logic [NB-1:0] m);
        @(negedge clk);
        if (chk_en) model_check();
        rst_n     = !rst;
        cmd_valid = v;
        cmd       = 3'(c);
        cmd_bank  = BW'(b);
        cmd_row   = ROW_W'(row);
        cmd_col   = COL_W'(col);
        wr_data   = d;
        wr_mask   = m;
        if (rst) model_reset();
        else if (v) model_apply(c, b, row, col, d, m);
        else exp_err = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop();
        step(1'b0, 1'b0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic issue(input int c, input int b, input int row, input int col,
                         input logic [DATA_W-1:0] d, input logic [NB-1:0] m);
        step(1'b0, 1'b1, c, b, row, col, d, m);
    endtask

    task automatic idle_until(input int t);
        while (cyc < t) nop();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);
        chk_en = 1'b1;
        step(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 1'b0);
        check({tag, "_rd_data"}, rd_data, 32'h0);
        check({tag, "_cmd_err"}, cmd_err, 1'b0);
        check({tag, "_err_code"}, err_code, 3'd0);
        check({tag, "_bank_open"}, bank_open, 4'h0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int base, r, p, n, lst;
        logic [DATA_W-1:0] wd [4];

        do_reset();
        check_reset_outputs("reset");

        // Basic write then read on bank 1.
        base = cyc;
        issue(1, 1, 8'h12, 0, '0, '0);
        idle_until(base + 4);
        issue(3, 1, 0, 3, 32'hA5A55A5A, 4'hF);
        issue(2, 1, 0, 3, '0, '0);
        idle_until(base + 11);
        check("t1_rd_valid", rd_valid, 1'b1);
        check("t1_rd_data", rd_data, 32'hA5A55A5A);
        check("t1_cmd_err", cmd_err, 1'b0);
        $display("t1 write/read bank1 done at cycle %0d", cyc);

        // Read before tRCD is rejected.
        do_reset();
        base = cyc;
        issue(1, 0, 5, 0, '0, '0);
        idle_until(base + 3);
        issue(2, 0, 0, 7, '0, '0);
        check("t2_cmd_err", cmd_err, 1'b1);
        check("t2_err_code", err_code, 3'd4);
        issue(2, 0, 0, 7, '0, '0);
        idle_until(base + 10);
        check("t2_rd_valid", rd_valid, 1'b1);
        $display("t2 early read rejected, retry returned at cycle %0d", cyc);

        // Byte-masked overwrite.
        do_reset();
        base = cyc;
        issue(1, 0, 8'h33, 0, '0, '0);
        idle_until(base + 4);
        issue(3, 0, 0, 9, 32'hFFFFFFFF, 4'hF);
        issue(3, 0, 0, 9, 32'h00000000, 4'b0101);
        r = cyc;
        issue(2, 0, 0, 9, '0, '0);
        idle_until(r + CL);
        check("t3_rd_valid", rd_valid, 1'b1);
        check("t3_rd_data", rd_data, 32'hFF00FF00);
        $display("t3 masked write readback %0h", rd_data);

        // tRAS/tWR gate precharge, tRP gates re-activation.
        do_reset();
        base = cyc;
        issue(1, 2, 1, 0, '0, '0);
        idle_until(base + 4);
        issue(3, 2, 0, 1, 32'h12345678, 4'hF);
        idle_until(base + 9);
        issue(4, 2, 0, 0, '0, '0);
        check("t4_pre_err", cmd_err, 1'b1);
        check("t4_pre_code", err_code, 3'd5);
        issue(4, 2, 0, 0, '0, '0);
        check("t4_pre_ok", cmd_err, 1'b0);
        check("t4_closed", bank_open[2], 1'b0);
        idle_until(base + 13);
        issue(1, 2, 1, 0, '0, '0);
        check("t4_act_code", err_code, 3'd2);
        issue(1, 2, 1, 0, '0, '0);
        check("t4_act_ok", cmd_err, 1'b0);
        check("t4_open", bank_open[2], 1'b1);
        $display("t4 precharge timing done at cycle %0d", cyc);

        // Refresh rules and tRFC.
        do_reset();
        base = cyc;
        issue(1, 3, 4, 0, '0, '0);
        issue(5, 0, 0, 0, '0, '0);
        check("t5_ref_open_code", err_code, 3'd6);
        idle_until(base + T_RAS);
        p = cyc;
        issue(4, 3, 0, 0, '0, '0);
        idle_until(p + T_RP);
        n = cyc;
        issue(5, 0, 0, 0, '0, '0);
        check("t5_ref_ok", cmd_err, 1'b0);
        while (cyc < n + 19) begin
            check("t5_busy", busy, 1'b1);
            nop();
        end
        check("t5_busy_last", busy, 1'b1);
        issue(1, 0, 2, 0, '0, '0);
        check("t5_act_code", err_code, 3'd2);
        check("t5_idle", busy, 1'b0);
        issue(1, 0, 2, 0, '0, '0);
        check("t5_act_ok", cmd_err, 1'b0);
        check("t5_open", bank_open[0], 1'b1);
        $display("t5 refresh timing done at cycle %0d", cyc);

        // Back-to-back reads, then a reset that drops in-flight reads.
        do_reset();
        base = cyc;
        issue(1, 0, 8'h40, 0, '0, '0);
        idle_until(base + 4);
        for (int k = 0; k < 4; k++) begin
            wd[k] = $urandom;
            issue(3, 0, 0, k, wd[k], 4'hF);
        end
        r = cyc;
        for (int k = 0; k < 4; k++) issue(2, 0, 0, k, '0, '0);
        idle_until(r + CL);
        for (int k = 0; k < 4; k++) begin
            check("t6_b2b_valid", rd_valid, 1'b1);
            check("t6_b2b_data", rd_data, wd[k]);
            nop();
        end
        for (int k = 0; k < 4; k++) issue(2, 0, 0, k, '0, '0);
        lst = cyc - 1;
        nop();
        step(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);
        for (int k = 0; k < CL + 2; k++) begin
            check("t6_dropped", rd_valid, 1'b0);
            nop();
        end
        check_reset_outputs("t6_after_reset");
        $display("t6 back-to-back reads and reset drop done, last RD at %0d", lst);

        // Random traffic scored by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            int sel = $urandom_range(0, 99);
            int c;
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b0, 0, 0, 0, 0, '0, '0);
                continue;
            end
            if (sel < 25) c = 1;
            else if (sel < 50) c = 2;
            else if (sel < 70) c = 3;
            else if (sel < 85) c = 4;
            else if (sel < 90) c = 5;
            else if (sel < 95) c = 0;
            else c = 6 + $urandom_range(0, 1);
            step(1'b0, ($urandom_range(0, 9) != 0), c, $urandom_range(0, BANKS - 1),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom, NB'($urandom));
        end
        for (int k = 0; k < CL + 2; k++) nop();
        $display("random phase done at cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lpddr5_bank_timing_model.md
Name: lpddr5_bank_timing_model

Overview:
Cycle-accurate, parametrised multi-bank LPDDR5 behavioural model for controller verification. It tracks each bank independently, with its own open row and tRCD/tRAS/tRP/tWR counters, plus a global tRFC counter. Read data returns through a fixed-CL pipelined path, and writes honour per-byte masks. Every timing or protocol violation is reported with an error code instead of being silently ignored. It sits behind the LPDDR5 controller in block and top-level benches.

Parameters:
BANKS, 4, number of banks (power of 2, >=2)
ROW_W, 8, row address width
COL_W, 6, column address width
DATA_W, 32, data word width (multiple of 8)
T_RCD, 4, ACT to RD/WR, cycles
T_RP, 4, PRE to ACT same bank, cycles
T_RAS, 10, ACT to PRE same bank, cycles
T_WR, 6, WR to PRE same bank, cycles
T_RFC, 20, REF to any ACT/REF, cycles
CL, 6, RD accept to rd_valid, cycles (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present this cycle
cmd  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 reserved
cmd_bank  in  $clog2(BANKS)  target bank
cmd_row  in  ROW_W  row (ACT only)
cmd_col  in  COL_W  column (RD/WR)
wr_data  in  DATA_W  write data, sampled with WR
wr_mask  in  DATA_W/8  byte enables for WR, 1 = write byte
rd_data  out  DATA_W  read data
rd_valid  out  1  rd_data valid
cmd_err  out  1  one-cycle pulse: the previous cycle's command was rejected
err_code  out  3  reason for the rejection; held until the next error
bank_open  out  BANKS  per-bank ACTIVE flag
busy  out  1  any timing counter non-zero

Behaviour:
- Reset (rst_n=0 at clk edge): all banks IDLE, all counters 0, read pipeline flushed. rd_valid=0, rd_data=0, cmd_err=0, err_code=0, bank_open=0, busy=0. Memory contents are preserved. A reset during an in-flight read drops that read: no rd_valid is produced.
- Bank state per bank: IDLE or ACTIVE. Each bank holds open_row[ROW_W].
- Storage: BANKS*2^(ROW_W+COL_W) words, indexed {bank, open_row, col}.
- Counters: loaded with T_x in the cycle the command is accepted. Each counter decrements by 1 per cycle while non-zero; a load overrides the decrement. A dependent command is legal when its counter reads 0, so the earliest legal issue is accept cycle + T_x.
- Command rules, with the error code used on violation:
  - ACT: bank must be IDLE (code 1). Bank rp==0 and rfc==0 are also required (code 2). Effect: bank becomes ACTIVE, open_row<=cmd_row, rcd<=T_RCD, ras<=T_RAS.
  - RD/WR: bank must be ACTIVE (code 3) and rcd==0 (code 4).
  - RD: memory is read at accept. rd_valid=1 with that data exactly CL cycles later. One read is accepted per cycle, fully pipelined; back-to-back reads give back-to-back rd_valid. rd_data holds its last value when rd_valid=0.
  - WR: bytes with wr_mask=1 are written in the accept cycle; other bytes are unchanged. Bank wr<=T_WR. A RD to the same word in the next cycle returns the new data.
  - PRE to an ACTIVE bank: requires ras==0 and wr==0 (code 5). Effect: bank becomes IDLE, rp<=T_RP.
  - PRE to an IDLE bank: treated as a NOP; no error, rp not reloaded.
  - REF: all banks IDLE, all rp==0 and rfc==0 (code 6). Effect: rfc<=T_RFC.
  - Reserved encodings 6-7 with cmd_valid=1: code 7.
- A rejected command has no state effect. cmd_err pulses in the cycle after the rejection and err_code updates in that same cycle.
- cmd_valid=0, or cmd=NOP: no effect.
- busy = OR of all per-bank rcd/ras/rp/wr counters and rfc.
- Different banks are independent. ACT to bank B is legal while bank A is ACTIVE or counting.
- An ACT to a bank issued in the same cycle that bank's rp reaches 0 is legal, because the counter is sampled before the decrement.

Test Plan:
- Reset, then ACT bank1 row 0x12 @c0; WR col3 data 0xA5A55A5A mask 0xF @c4; RD col3 @c5 -> rd_valid=1 @c11 with rd_data=0xA5A55A5A; no cmd_err.
- ACT bank0 @c0; RD @c3 -> cmd_err=1 @c4, err_code=4, no rd_valid; RD @c4 -> rd_valid @c10.
- WR 0xFFFFFFFF mask 0xF, then WR 0x00000000 mask 0b0101 to the same address, then RD -> rd_data=0xFF00FF00.
- ACT bank2 @c0, WR @c4; PRE @c9 -> err_code=5 (both tRAS and tWR pending); PRE @c10 -> accepted, bank_open[2]=0; ACT @c13 -> err_code=2; ACT @c14 -> accepted.
- REF with bank3 open -> err_code=6. After PRE plus T_RP, REF @cN is accepted; ACT @cN+19 -> err_code=2; ACT @cN+20 -> accepted; busy=1 during cN+1..cN+19.
- Four RDs on consecutive cycles to cols 0-3 -> rd_valid high for four consecutive cycles with matching data. A second run asserts rst_n=0 two cycles after the last RD -> no rd_valid afterwards, and all outputs are at their reset values.
